// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage.
//
// Holds the program counter and fetches one instruction at a time from
// instruction memory over a req/ack handshake. The fetched word is registered
// and presented to decode/control. In the same cycle, the control unit's jump
// and branch flags are used to form the next PC. Wait states on the memory
// side and stalls from downstream are both absorbed here.
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   imem_req_o        fetch request, held until imem_ack_i
//   imem_addr_o       fetch address (the current PC)
//   imem_ack_i        read data valid this cycle (honoured only in REQ)
//   imem_rdata_i      instruction word from memory
//   instr_o           registered current instruction
//   instr_valid_o     instr_o is executing this cycle
//   pc_o, pc_plus4_o  current PC and PC + 4 (jal link value)
//   stall_i           downstream not ready; hold current instruction
//   j_i, jal_i, jr_i  jump flags from control
//   branch_eq_i/_ne_i branch flags from control
//   zero_i            ALU zero flag
//   rs_data_i         jr target register value
//   misalign_o        pulses in a retire cycle whose jr target has low bits set
//   instr_count_o     retired-instruction counter (wraps)

module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0040_0000,
  parameter int unsigned IMEM_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  // instruction memory
  output logic                       imem_req_o,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_rdata_i,
  // decode / control side
  output logic [31:0]                instr_o,
  output logic                       instr_valid_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                pc_plus4_o,
  input  logic                       stall_i,
  input  logic                       j_i,
  input  logic                       jal_i,
  input  logic                       jr_i,
  input  logic                       branch_eq_i,
  input  logic                       branch_ne_i,
  input  logic                       zero_i,
  input  logic [31:0]                rs_data_i,
  output logic                       misalign_o,
  output logic [31:0]                instr_count_o
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StExec = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;
  logic [31:0] next_pc;
  logic        branch_taken;
  logic        retire;

  // ---------------------------------------------------------------------------
  // Next-PC selection. Evaluated every cycle, but only consumed on retire, so
  // flags seen in IDLE/REQ or during a stall have no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    // Word offset: sign-extend imm16, then shift left by two.
    branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_taken  = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);

    if (jr_i) begin
      // Low bits are dropped; misalign_o flags the lossy target instead.
      next_pc = {rs_data_i[31:2], 2'b00};
    end else if (j_i || jal_i) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_offset;
    end else begin
      next_pc = pc_plus4;
    end
  end

  assign retire = (state_q == StExec) && !stall_i;

  // ---------------------------------------------------------------------------
  // Control FSM and datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end
      StReq: begin
        // Address is pc_q, which cannot change here, so it stays stable
        // for the whole request.
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (retire) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_o    = (state_q == StReq);
  assign imem_addr_o   = IMEM_ADDR_WIDTH'(pc_q);
  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == StExec);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  // Combinational so the pulse lines up with the retiring instruction.
  assign misalign_o    = retire && jr_i && (rs_data_i[1:0] != 2'b00);
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. A small memory model answers fetches
// with chosen wait states; expected fetch addresses go into a queue when each
// instruction is retired and are popped when the DUT issues its next request.

module tb_pc_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        stall_i;
  logic        j_i, jal_i, jr_i, branch_eq_i, branch_ne_i, zero_i;
  logic [31:0] rs_data_i;
  logic        misalign_o;
  logic [31:0] instr_count_o;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_count;

  pc_fetch_unit #(
    .RESET_PC       (ResetPc),
    .IMEM_ADDR_WIDTH(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .stall_i      (stall_i),
    .j_i          (j_i),
    .jal_i        (jal_i),
    .jr_i         (jr_i),
    .branch_eq_i  (branch_eq_i),
    .branch_ne_i  (branch_ne_i),
    .zero_i       (zero_i),
    .rs_data_i    (rs_data_i),
    .misalign_o   (misalign_o),
    .instr_count_o(instr_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_flags();
    j_i = 0; jal_i = 0; jr_i = 0; branch_eq_i = 0; branch_ne_i = 0; zero_i = 0;
    rs_data_i = 32'd0;
  endtask

  // One complete instruction: fetch with `waits` wait states, hold `stalls`
  // cycles (with stray acks that must be ignored), then retire with the given
  // flags. exp_next is the expected following PC.
  task automatic run_instr(input logic [31:0] word, input int waits, input int stalls,
                           input logic [5:0] flags,  // {jr, j, jal, beq, bne, zero}
                           input logic [31:0] rs, input logic [31:0] exp_next,
                           input logic exp_mis);
    int n;
    logic [31:0] addr;
    n = 0;
    while (!imem_req_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", {31'd0, imem_req_o}, 32'd1);
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty: got fetch at %08h expected none", imem_addr_o);
      addr = 32'hxxxx_xxxx;
    end else begin
      addr = exp_q.pop_front();
    end
    check_eq("fetch_addr", imem_addr_o, addr);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check_eq("req_hold", {31'd0, imem_req_o}, 32'd1);
      check_eq("addr_hold", imem_addr_o, addr);
    end
    imem_ack_i = 1'b1;
    imem_rdata_i = word;
    @(negedge clk);
    imem_ack_i = 1'b0;
    imem_rdata_i = 32'hDEAD_BEEF;
    check_eq("valid", {31'd0, instr_valid_o}, 32'd1);
    check_eq("req_low_exec", {31'd0, imem_req_o}, 32'd0);
    check_eq("instr", instr_o, word);
    check_eq("pc_plus4", pc_plus4_o, addr + 32'd4);
    stall_i = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      imem_ack_i = 1'b1;  // must be ignored outside REQ
      imem_rdata_i = ~word;
      {jr_i, j_i, jal_i, branch_eq_i, branch_ne_i, zero_i} = flags;
      rs_data_i = rs;
      @(negedge clk);
      check_eq("stall_pc", pc_o, addr);
      check_eq("stall_instr", instr_o, word);
      check_eq("stall_mis", {31'd0, misalign_o}, 32'd0);
    end
    imem_ack_i = 1'b0;
    stall_i = 1'b0;
    {jr_i, j_i, jal_i, branch_eq_i, branch_ne_i, zero_i} = flags;
    rs_data_i = rs;
    #1;
    check_eq("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
    exp_q.push_back(exp_next);
    exp_count = exp_count + 32'd1;
    @(negedge clk);
    clear_flags();
    #1;
    check_eq("next_pc", pc_o, exp_next);
    check_eq("count", instr_count_o, exp_count);
    check_eq("mis_after", {31'd0, misalign_o}, 32'd0);
  endtask

  task automatic check_reset_state();
    check_eq("rst_pc", pc_o, ResetPc);
    check_eq("rst_req", {31'd0, imem_req_o}, 32'd0);
    check_eq("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check_eq("rst_count", instr_count_o, 32'd0);
    check_eq("rst_mis", {31'd0, misalign_o}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_count = 32'd0;
    reset = 1'b1;
    imem_ack_i = 1'b0;
    imem_rdata_i = 32'd0;
    stall_i = 1'b0;
    clear_flags();

    repeat (3) @(negedge clk);
    check_reset_state();
    check_eq("rst_instr", instr_o, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("idle_req", {31'd0, imem_req_o}, 32'd0);
    exp_q.push_back(ResetPc);

    // Plain instruction: 3 wait states, 2 stall cycles.
    run_instr(32'h2008_0005, 3, 2, 6'b000000, 32'd0, 32'h0040_0004, 1'b0);
    // Branch to self taken, then not taken (beq), then bne taken to self.
    run_instr(32'h1000_FFFF, 0, 0, 6'b000101, 32'd0, 32'h0040_0004, 1'b0);
    run_instr(32'h1000_FFFF, 1, 0, 6'b000100, 32'd0, 32'h0040_0008, 1'b0);
    run_instr(32'h1400_FFFF, 0, 1, 6'b000010, 32'd0, 32'h0040_0008, 1'b0);
    // jal at 0x0040_0008.
    run_instr(32'h0C10_0010, 2, 0, 6'b001000, 32'd0, 32'h0040_0040, 1'b0);
    // jr beats j; misaligned target.
    run_instr(32'h0800_0000, 0, 1, 6'b110000, 32'h0040_0023, 32'h0040_0020, 1'b1);
    // Forward branch, and bne with zero set (not taken).
    run_instr(32'h1000_0003, 0, 0, 6'b000101, 32'd0, 32'h0040_0030, 1'b0);
    run_instr(32'h1400_0003, 0, 0, 6'b000011, 32'd0, 32'h0040_0034, 1'b0);
    // Wrap-around: jump to the top word, step past it, then max negative branch.
    run_instr(32'h0000_0008, 0, 0, 6'b100000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    run_instr(32'h0000_0000, 1, 0, 6'b000000, 32'd0, 32'h0000_0000, 1'b0);
    run_instr(32'h1000_8000, 0, 0, 6'b000101, 32'd0, 32'hFFFE_0004, 1'b0);

    // Reset in the middle of a pending fetch.
    @(negedge clk);
    check_eq("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(ResetPc);
    exp_count = 32'd0;
    run_instr(32'h0000_0020, 0, 0, 6'b000000, 32'd0, 32'h0040_0004, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so a stuck DUT cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
